// File: rtl/button_port_pkg.sv
// Shared types and constants for the debounced button / switch register port.
// Latency: none (declarations only).
// Backpressure: none.
package button_port_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        WAIT_PRESS   = 2'd1,
        PRESSED      = 2'd2,
        WAIT_RELEASE = 2'd3
    } db_state_e;

    localparam logic [1:0] ADDR_STATUS      = 2'd0;
    localparam logic [1:0] ADDR_SWITCHES    = 2'd1;
    localparam logic [1:0] ADDR_CTRL        = 2'd2;
    localparam logic [1:0] ADDR_PRESS_COUNT = 2'd3;

    localparam int STAT_LEVEL_BIT   = 0;
    localparam int STAT_PRESS_BIT   = 1;
    localparam int STAT_REL_BIT     = 2;
    localparam int CTRL_IRQ_EN_BIT  = 0;
    localparam int CTRL_IRQ_REL_BIT = 1;

    // Press counter sticks at all-ones instead of wrapping back to zero.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/debounce_fsm.sv
// Synchronizes button/switches and debounces the button into a level plus press/release pulses.
// Latency: level changes DEBOUNCE_CYCLES+3 edges after a clean raw transition; switches 2 edges.
// Backpressure: none; events are single-cycle pulses that must be consumed when asserted.
module debounce_fsm
    import button_port_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50,
    parameter int SW_W            = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            button,
    input  logic [SW_W-1:0] switches,
    output logic            level,
    output logic            press_evt,
    output logic            rel_evt,
    output logic [SW_W-1:0] sw_sync
);

    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic            btn_meta_q, btn_meta_d;
    logic            btn_sync_q, btn_sync_d;
    logic [SW_W-1:0] sw_meta_q, sw_meta_d;
    logic [SW_W-1:0] sw_sync_q, sw_sync_d;
    db_state_e       state_q, state_d;
    logic [15:0]     cnt_q, cnt_d;

    // Two-stage synchronizers; button idles high (released) so reset loads 1.
    always_comb begin
        btn_meta_d = button;
        btn_sync_d = btn_meta_q;
        sw_meta_d  = switches;
        sw_sync_d  = sw_meta_q;
    end

    // State, counter and synchronizer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_meta_q <= 1'b1;
            btn_sync_q <= 1'b1;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            state_q    <= RELEASED;
            cnt_q      <= '0;
        end else begin
            btn_meta_q <= btn_meta_d;
            btn_sync_q <= btn_sync_d;
            sw_meta_q  <= sw_meta_d;
            sw_sync_q  <= sw_sync_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
        end
    end

    // Debounce next-state: any sample back at the old level aborts the pending change.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_evt = 1'b0;
        rel_evt   = 1'b0;
        case (state_q)
            RELEASED: begin
                if (!btn_sync_q) begin
                    state_d = WAIT_PRESS;
                    cnt_d   = '0;
                end
            end
            WAIT_PRESS: begin
                if (btn_sync_q) begin
                    state_d = RELEASED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = PRESSED;
                    press_evt = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            PRESSED: begin
                if (btn_sync_q) begin
                    state_d = WAIT_RELEASE;
                    cnt_d   = '0;
                end
            end
            WAIT_RELEASE: begin
                if (!btn_sync_q) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RELEASED;
                    rel_evt = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = RELEASED;
        endcase
    end

    assign level   = (state_q == PRESSED) || (state_q == WAIT_RELEASE);
    assign sw_sync = sw_sync_q;

endmodule

// File: rtl/button_debounce_port.sv
// Register port exposing a debounced button (status, W1C flags, press count) and switches.
// Latency: rdata one edge after addr (read-before-write); irq one edge after flag/CTRL change.
// Backpressure: none; a write is accepted on every cycle we is high.
module button_debounce_port
    import button_port_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50,
    parameter int SW_W            = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            button,
    input  logic [SW_W-1:0] switches,
    input  logic [1:0]      addr,
    input  logic            we,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic            irq
);

    logic            level, press_evt, rel_evt;
    logic [SW_W-1:0] sw_sync;

    debounce_fsm #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SW_W            (SW_W)
    ) u_debounce (
        .clk       (clk),
        .reset     (reset),
        .button    (button),
        .switches  (switches),
        .level     (level),
        .press_evt (press_evt),
        .rel_evt   (rel_evt),
        .sw_sync   (sw_sync)
    );

    logic        press_pend_q, press_pend_d;
    logic        rel_pend_q, rel_pend_d;
    logic        irq_en_q, irq_en_d;
    logic        irq_on_rel_q, irq_on_rel_d;
    logic [15:0] press_cnt_q, press_cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        irq_q, irq_d;

    logic wr_status, wr_ctrl, wr_cnt;
    logic unused_wdata_hi;

    assign unused_wdata_hi = ^wdata[31:3];

    // Register file next-state: W1C loses to a same-cycle set, count clear loses to increment.
    always_comb begin
        wr_status = we && (addr == ADDR_STATUS);
        wr_ctrl   = we && (addr == ADDR_CTRL);
        wr_cnt    = we && (addr == ADDR_PRESS_COUNT);

        press_pend_d = press_evt | (press_pend_q & ~(wr_status & wdata[STAT_PRESS_BIT]));
        rel_pend_d   = rel_evt   | (rel_pend_q   & ~(wr_status & wdata[STAT_REL_BIT]));

        irq_en_d     = irq_en_q;
        irq_on_rel_d = irq_on_rel_q;
        if (wr_ctrl) begin
            irq_en_d     = wdata[CTRL_IRQ_EN_BIT];
            irq_on_rel_d = wdata[CTRL_IRQ_REL_BIT];
        end

        press_cnt_d = press_cnt_q;
        if (wr_cnt) begin
            press_cnt_d = press_evt ? 16'd1 : 16'd0;
        end else if (press_evt) begin
            press_cnt_d = sat_inc16(press_cnt_q);
        end

        // Reads see the pre-write contents of this cycle.
        rdata_d = '0;
        case (addr)
            ADDR_STATUS:      rdata_d = 32'({rel_pend_q, press_pend_q, level});
            ADDR_SWITCHES:    rdata_d = 32'(sw_sync);
            ADDR_CTRL:        rdata_d = 32'({irq_on_rel_q, irq_en_q});
            ADDR_PRESS_COUNT: rdata_d = 32'(press_cnt_q);
            default:          rdata_d = '0;
        endcase

        irq_d = (press_pend_q & irq_en_q) | (rel_pend_q & irq_en_q & irq_on_rel_q);
    end

    // Register file, read data and interrupt registers; reset overrides writes and events.
    always_ff @(posedge clk) begin
        if (reset) begin
            press_pend_q <= 1'b0;
            rel_pend_q   <= 1'b0;
            irq_en_q     <= 1'b0;
            irq_on_rel_q <= 1'b0;
            press_cnt_q  <= '0;
            rdata_q      <= '0;
            irq_q        <= 1'b0;
        end else begin
            press_pend_q <= press_pend_d;
            rel_pend_q   <= rel_pend_d;
            irq_en_q     <= irq_en_d;
            irq_on_rel_q <= irq_on_rel_d;
            press_cnt_q  <= press_cnt_d;
            rdata_q      <= rdata_d;
            irq_q        <= irq_d;
        end
    end

    assign rdata = rdata_q;
    assign irq   = irq_q;

endmodule

// File: tb/tb_button_debounce_port.sv
// Directed bench for button_debounce_port with a run-length reference model.
// Latency: model tracks rdata/irq one edge after the state they report.
// Backpressure: none.
module tb_button_debounce_port;

    localparam int D    = 4;
    localparam int SW_W = 10;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            button = 1'b1;
    logic [SW_W-1:0] switches = '0;
    logic [1:0]      addr = 2'd0;
    logic            we = 1'b0;
    logic [31:0]     wdata = '0;
    logic [31:0]     rdata;
    logic            irq;

    button_debounce_port #(
        .DEBOUNCE_CYCLES (D),
        .SW_W            (SW_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .button   (button),
        .switches (switches),
        .addr     (addr),
        .we       (we),
        .wdata    (wdata),
        .rdata    (rdata),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: raw inputs delayed two samples, a level flips once the
    // synchronized button has disagreed with it for D+1 consecutive samples.
    bit              m_valid = 1'b0;
    bit              m_b1, m_b2, m_s;
    logic [SW_W-1:0] m_sw1, m_sw2;
    int              m_run;
    bit              m_level, m_pp, m_rp, m_en, m_onrel, m_pe, m_re, m_irq, m_irq_next;
    int              m_cnt;
    logic [31:0]     m_rdata, m_rd;

    always @(posedge clk) begin
        if (reset) begin
            m_valid = 1'b1;
            m_b1 = 1'b1; m_b2 = 1'b1; m_sw1 = '0; m_sw2 = '0; m_run = 0;
            m_level = 0; m_pp = 0; m_rp = 0; m_en = 0; m_onrel = 0;
            m_cnt = 0; m_rdata = '0; m_irq = 0;
        end else if (m_valid) begin
            case (addr)
                2'd0:    m_rd = {29'd0, m_rp, m_pp, m_level};
                2'd1:    m_rd = 32'(m_sw2);
                2'd2:    m_rd = {30'd0, m_onrel, m_en};
                default: m_rd = 32'(m_cnt);
            endcase
            m_irq_next = m_en && (m_pp || (m_rp && m_onrel));

            m_s = m_b2; m_b2 = m_b1; m_b1 = button;
            m_sw2 = m_sw1; m_sw1 = switches;

            m_pe = 0; m_re = 0;
            if (m_s != !m_level) begin
                m_run++;
                if (m_run == D + 1) begin
                    m_level = !m_level;
                    m_run = 0;
                    if (m_level) m_pe = 1; else m_re = 1;
                end
            end else begin
                m_run = 0;
            end

            if (we && addr == 2'd0) begin
                if (wdata[1]) m_pp = 0;
                if (wdata[2]) m_rp = 0;
            end
            if (m_pe) m_pp = 1;
            if (m_re) m_rp = 1;
            if (we && addr == 2'd2) begin
                m_en = wdata[0];
                m_onrel = wdata[1];
            end
            if (we && addr == 2'd3) m_cnt = 0;
            if (m_pe) m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;

            m_rdata = m_rd;
            m_irq = m_irq_next;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            check("rdata_vs_model", rdata, m_rdata);
            check("irq_vs_model", {31'd0, irq}, {31'd0, m_irq});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr = a; we = 1'b1; wdata = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        addr = a;
        @(negedge clk);
        v = rdata;
    endtask

    logic [31:0] v;

    initial begin
        tick(3);
        check("reset_rdata", rdata, 32'h0);
        check("reset_irq", {31'd0, irq}, 32'h0);
        reset = 1'b0;

        // Idle released button.
        tick(2000);
        rd(2'd0, v); check("idle_status", v, 32'h0);
        rd(2'd3, v); check("idle_count", v, 32'h0);
        check("idle_irq", {31'd0, irq}, 32'h0);

        // Glitches of 3 and D cycles are rejected.
        button = 1'b0; tick(3); button = 1'b1; tick(20);
        rd(2'd0, v); check("glitch3_status", v, 32'h0);
        button = 1'b0; tick(D); button = 1'b1; tick(20);
        rd(2'd0, v); check("glitch4_status", v, 32'h0);
        rd(2'd3, v); check("glitch_count", v, 32'h0);

        // Clean press, level visible in STATUS register on edge 7, read back on edge 8.
        wr(2'd2, 32'h1);
        addr = 2'd0; button = 1'b0;
        tick(7);
        check("press_edge7_status", rdata, 32'h0);
        check("press_edge7_irq", {31'd0, irq}, 32'h0);
        tick(1);
        check("press_edge8_status", rdata, 32'h3);
        check("press_edge8_irq", {31'd0, irq}, 32'h1);
        tick(100);
        rd(2'd3, v); check("press_count", v, 32'h1);

        // W1C of press_pend, irq drops one edge later; release with irq_on_release.
        wr(2'd0, 32'h2);
        check("w1c_irq_same_edge", {31'd0, irq}, 32'h1);
        tick(1);
        check("w1c_irq_dropped", {31'd0, irq}, 32'h0);
        rd(2'd0, v); check("w1c_status", v, 32'h1);
        wr(2'd2, 32'h3);
        button = 1'b1; tick(20);
        rd(2'd0, v); check("release_status", v, 32'h4);
        check("release_irq", {31'd0, irq}, 32'h1);
        wr(2'd0, 32'h4);

        // Set wins over a same-edge W1C of press_pend.
        addr = 2'd0; button = 1'b0;
        tick(6);
        we = 1'b1; wdata = 32'h2;
        tick(1);
        we = 1'b0;
        tick(1);
        check("set_wins_status", rdata, 32'h3);

        // Count clear on the same edge as an increment leaves 1.
        button = 1'b1; tick(20); wr(2'd0, 32'h6);
        addr = 2'd3; button = 1'b0;
        tick(6);
        we = 1'b1; wdata = 32'h0;
        tick(1);
        we = 1'b0;
        check("count_before_clear", rdata, 32'h2);
        tick(1);
        check("count_clear_vs_inc", rdata, 32'h1);
        wr(2'd0, 32'h6); button = 1'b1; tick(20); wr(2'd0, 32'h6); tick(2);

        // Reset two cycles into WAIT_PRESS abandons the press; held button re-accepted.
        addr = 2'd0; button = 1'b0;
        tick(4);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(7);
        check("rst_mid_wait_edge7", rdata, 32'h0);
        tick(1);
        check("rst_mid_wait_edge8", rdata, 32'h3);
        rd(2'd3, v); check("rst_mid_wait_count", v, 32'h1);

        // Switches through the synchronizer, writes ignored.
        addr = 2'd1; switches = 10'd4;
        tick(2);
        check("switches_edge2", rdata, 32'h0);
        tick(1);
        check("switches_edge3", rdata, 32'h4);
        wr(2'd1, 32'hFF);
        rd(2'd1, v); check("switches_ro", v, 32'h4);
        wr(2'd2, 32'hFFFF_FFFF);
        rd(2'd2, v); check("ctrl_mask", v, 32'h3);

        // Reset takes priority over a same-cycle CTRL write.
        reset = 1'b1; we = 1'b1; addr = 2'd2; wdata = 32'h1;
        tick(1);
        reset = 1'b0; we = 1'b0;
        check("reset_prio_rdata", rdata, 32'h0);
        rd(2'd2, v); check("reset_prio_ctrl", v, 32'h0);
        tick(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/button_debounce_port.md
BUTTON_DEBOUNCE_PORT -- requirements
Module: button_debounce_port

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50, number of consecutive stable synchronized samples required to accept a button level change; legal range 2..65535.
REQ-002 Parameter SW_W, default 10, switch bank width; legal range 1..32.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 button  input  1  raw asynchronous push-button, active-low (1 = released, 0 = pressed).
REQ-006 switches  input  SW_W  raw asynchronous switch levels.
REQ-007 addr  input  2  register word select: 0 STATUS, 1 SWITCHES, 2 CTRL, 3 PRESS_COUNT.
REQ-008 we  input  1  write strobe, one write per cycle it is high.
REQ-009 wdata  input  32  write data.
REQ-010 rdata  output  32  registered read data for the register selected by addr on the previous edge.
REQ-011 irq  output  1  registered interrupt request, level.

Function
REQ-012 button and switches SHALL each pass through a 2-flop synchronizer before any other use.
REQ-013 Debounce FSM states SHALL be RELEASED, WAIT_PRESS, PRESSED, WAIT_RELEASE.
REQ-014 RELEASED: synchronized button = 0 -> WAIT_PRESS with cnt = 0; otherwise stay.
REQ-015 WAIT_PRESS: synchronized button = 1 -> RELEASED; else cnt = DEBOUNCE_CYCLES-1 -> PRESSED; else cnt increments.
REQ-016 PRESSED/WAIT_RELEASE SHALL mirror REQ-014/015 with polarity inverted, returning to RELEASED on acceptance.
REQ-017 A clean raw press SHALL make STATUS.level = 1 exactly DEBOUNCE_CYCLES+3 rising edges after the raw transition; release likewise.
REQ-018 A raw pulse shorter than DEBOUNCE_CYCLES cycles SHALL change no register.
REQ-019 Entry into PRESSED SHALL set STATUS.press_pend (bit 1) and increment PRESS_COUNT (16-bit, saturating at 0xFFFF).
REQ-020 Entry into RELEASED from WAIT_RELEASE SHALL set STATUS.rel_pend (bit 2).
REQ-021 STATUS bit 0 = debounced level (1 = pressed); bits 31:3 read 0.
REQ-022 Write to STATUS SHALL clear press_pend/rel_pend for each wdata bit 1/2 set (write-1-to-clear); bit 0 ignored.
REQ-023 Simultaneous set event and W1C on the same flag in one cycle: set wins.
REQ-024 SWITCHES SHALL read the synchronized switches zero-extended; writes ignored.
REQ-025 CTRL bit 0 = irq_en, bit 1 = irq_on_release; read/write; bits 31:2 read 0.
REQ-026 Write to PRESS_COUNT with any data SHALL clear it to 0; increment in the same cycle: result is 1.
REQ-027 irq SHALL equal (press_pend & irq_en) | (rel_pend & irq_en & irq_on_release), registered one cycle after flag/CTRL update.
REQ-028 rdata SHALL reflect register contents after any same-cycle write has not yet taken effect (read-before-write), one-cycle latency.

Reset
REQ-029 reset SHALL force FSM = RELEASED, cnt = 0, synchronizer flops button = 1 / switches = 0, all flags 0, CTRL = 0, PRESS_COUNT = 0, rdata = 0, irq = 0.
REQ-030 reset asserted mid-WAIT_PRESS SHALL abandon the pending press: no flag set, no count increment.
REQ-031 reset SHALL take priority over we and FSM events in the same cycle.

Structure
REQ-032 Shared package button_port_pkg SHALL hold the FSM state enum, register address constants (ADDR_STATUS..ADDR_PRESS_COUNT) and STATUS/CTRL bit-position constants.
REQ-033 The synchronizer plus FSM SHALL be a sub-module debounce_fsm outputting level, press_evt and rel_evt single-cycle pulses; register file and irq logic stay in button_debounce_port.

Verification (DEBOUNCE_CYCLES = 4)
REQ-034 button held 1 for 2000 cycles after reset -> STATUS reads 0x0, PRESS_COUNT 0, irq 0.
REQ-035 button 1->0 held 100 cycles, irq_en = 1 -> STATUS.level rises on edge 7, STATUS reads 0x3, PRESS_COUNT 1, irq 1 one edge after press_pend.
REQ-036 button 0 for 3 cycles then 1 -> STATUS stays 0x0, PRESS_COUNT 0.
REQ-037 After press, write STATUS 0x2 -> STATUS reads 0x1, irq drops next edge; release with irq_on_release = 1 -> STATUS reads 0x4, irq 1.
REQ-038 reset pulsed 2 cycles into WAIT_PRESS -> after reset STATUS 0x0, PRESS_COUNT 0; button still held low -> press accepted 7 edges after reset deasserts.
REQ-039 switches = 10'd4 -> SWITCHES reads 0x00000004 by the 3rd edge plus one read-latency cycle.
